seven_seg_scan_controller: RTL and testbench

Time-multiplexes a 4-digit BCD value onto the Basys 3 common-anode 7-segment display. It sequences one shared display_map_7seg decoder across the four digits and drives anodes, cathodes and decimal point. A guard interval between digits prevents ghosting. Updates are double-buffered so a new value is only applied at a frame boundary and never tears.

---
 rtl/seven_seg_pkg.sv | 13 +
 rtl/display_map_7seg.sv | 23 ++
 rtl/seven_seg_scan_controller.sv | 126 ++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
package seven_seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;

endpackage

// File: rtl/display_map_7seg.sv
// BCD digit to common-anode segment pattern {g..a}, active-low; non-BCD codes go dark.
module display_map_7seg (
    input  logic [3:0] digit_in,
    output logic [6:0] seg_out
);

    always_comb begin
        case (digit_in)
            4'd0:    seg_out = 7'b1000000;
            4'd1:    seg_out = 7'b1111001;
            4'd2:    seg_out = 7'b0100100;
            4'd3:    seg_out = 7'b0110000;
            4'd4:    seg_out = 7'b0011001;
            4'd5:    seg_out = 7'b0010010;
            4'd6:    seg_out = 7'b0000010;
            4'd7:    seg_out = 7'b1111000;
            4'd8:    seg_out = 7'b0000000;
            4'd9:    seg_out = 7'b0010000;
            default: seg_out = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Scans a double-buffered 4-digit BCD value across a common-anode display,
// with a blank guard at the start of every digit slot to avoid ghosting.
module seven_seg_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] value_in,
    input  logic        load_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en_in,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  an_out,
    output logic        frame_done_out
);

    localparam int              CNT_W      = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]  active_q, active_d;
    logic [4*NUM_DIGITS-1:0]  shadow_q, shadow_d;
    logic                     pending_q, pending_d;
    logic [6:0]               seg_q, seg_d;
    logic [3:0]               an_q, an_d;
    logic                     dp_q, dp_d;
    logic                     frame_done_q, frame_done_d;

    logic                     boundary;
    logic [4*NUM_DIGITS-1:0]  upper;
    logic [3:0]               nibble;
    logic                     digit_blank;
    logic [6:0]               dec_seg;

    display_map_7seg u_map (
        .digit_in (nibble),
        .seg_out  (dec_seg)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latches are inferred.
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        seg_d        = SEG_BLANK;
        an_d         = AN_OFF;
        dp_d         = 1'b1;

        case (state_q)
            ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
            ST_DRIVE: if (cnt_q == SLOT_LAST) begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                idx_d   = idx_q + 2'd1;
            end
            default:  state_d = ST_BLANK;
        endcase

        // A load on the frame boundary bypasses the shadow so it shows without a frame of delay.
        boundary = (state_q == ST_DRIVE) && (idx_q == 2'd3) && (cnt_q == SLOT_LAST);
        if (boundary) begin
            pending_d = 1'b0;
            if (load_in)        active_d = value_in;
            else if (pending_q) active_d = shadow_q;
        end else if (load_in) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end

        // Outputs are registered from next-state values so they change on the same edge as the FSM.
        upper       = active_d >> {idx_d, 2'b00};
        nibble      = upper[3:0];
        digit_blank = (nibble > 4'd9) || (lz_en_in && (idx_d != 2'd0) && (upper == '0));

        if (state_d == ST_DRIVE) begin
            an_d  = digit_blank ? AN_OFF : ~(4'b0001 << idx_d);
            seg_d = digit_blank ? SEG_BLANK : dec_seg;
            dp_d  = ~dp_in[idx_d];
        end

        frame_done_d = (state_d == ST_DRIVE) && (idx_d == 2'd3) && (cnt_d == SLOT_LAST);
    end

    // NOTE: asynchronous reset in the sensitivity list; all state uses non-blocking assignment.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out        = seg_q;
    assign an_out         = an_q;
    assign dp_out         = dp_q;
    assign frame_done_out = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for seven_seg_scan_controller with 8-cycle slots and a 2-cycle guard.
module tb_seven_seg_scan_controller;

    localparam int DIGIT_CYCLES = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 4 * DIGIT_CYCLES;
    localparam logic [6:0] B    = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp_o;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;
    bit in_rst   = 1'b1;

    seven_seg_scan_controller #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .value_in       (value),
        .load_in        (load),
        .dp_in          (dp),
        .lz_en_in       (lz_en),
        .seg_out        (seg),
        .dp_out         (dp_o),
        .an_out         (an),
        .frame_done_out (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
        logic [27:0] segs;   // {d3, d2, d1, d0}
        logic [3:0]  blank;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s pos=%0d actual=%h expected=%h", name, pos, act, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the edge and police the per-cycle invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        pos = (pos + 1) % FRAME;
        if (!in_rst) begin
            check("frame_done", 32'(frame_done), 32'(pos == FRAME - 1));
            if ((pos % DIGIT_CYCLES) < BLANK_CYCLES) check("guard_an", 32'(an), 32'hF);
        end
    endtask

    task automatic wait_pos(input int p);
        for (int k = 0; k < 2 * FRAME && pos != p; k++) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic check_digit(input string name, input int d, input logic [6:0] exp_seg,
                               input logic [3:0] exp_an, input logic exp_dp);
        wait_pos(d * DIGIT_CYCLES + BLANK_CYCLES);
        check({name, "_an"}, 32'(an), 32'(exp_an));
        check({name, "_seg"}, 32'(seg), 32'(exp_seg));
        check({name, "_dp"}, 32'(dp_o), 32'(exp_dp));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        pos    = 0;
        in_rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b0000};
        vecs[1] = '{16'h9999, 4'b0000, 1'b0, {4{7'b0010000}}, 4'b0000};
        vecs[2] = '{16'h0007, 4'b0000, 1'b1, {B, B, B, 7'b1111000}, 4'b1110};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {B, B, B, 7'b1000000}, 4'b1110};
        vecs[4] = '{16'h0100, 4'b0000, 1'b1, {B, 7'b1111001, 7'b1000000, 7'b1000000}, 4'b1000};
        vecs[5] = '{16'h00A5, 4'b0010, 1'b0, {7'b1000000, 7'b1000000, B, 7'b0010010}, 4'b0010};
        vecs[6] = '{16'h8060, 4'b1001, 1'b1, {7'b0000000, 7'b1000000, 7'b0000010, 7'b1000000}, 4'b0000};
        vecs[7] = '{16'hF000, 4'b0000, 1'b1, {B, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1000};

        rst_n = 1'b0;
        value = '0;
        load  = 1'b0;
        dp    = '0;
        lz_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'(B));
        check("rst_dp", 32'(dp_o), 32'h1);
        check("rst_fd", 32'(frame_done), 32'h0);

        // Reset release: guard then digit 0 showing "0" for the rest of the slot.
        release_reset();
        tick();
        check("post_rst_guard_seg", 32'(seg), 32'(B));
        check_digit("first_d0", 0, 7'b1000000, 4'b1110, 1'b1);
        wait_pos(DIGIT_CYCLES - 1);
        check("first_d0_last_an", 32'(an), 32'hE);
        check("first_d0_last_seg", 32'(seg), 32'b1000000);

        for (int i = 0; i < 8; i++) begin
            wait_pos(10);
            lz_en = vecs[i].lz;
            dp    = vecs[i].dp;
            do_load(vecs[i].value);
            if (i == 0) begin
                // The new value must not tear into the current frame.
                wait_pos(18);
                check("hold_old_an", 32'(an), 32'hB);
                check("hold_old_seg", 32'(seg), 32'b1000000);
                wait_pos(FRAME - 1);
                check("d3_last_an", 32'(an), 32'h7);
            end
            wait_pos(FRAME - 1);
            for (int d = 0; d < 4; d++) begin
                logic [3:0] one_hot;
                one_hot = 4'b0001 << d;
                check_digit($sformatf("vec%0d_d%0d", i, d), d, vecs[i].segs[7*d +: 7],
                            vecs[i].blank[d] ? 4'hF : ~one_hot, ~vecs[i].dp[d]);
            end
        end

        // Two loads in one frame: the last one wins.
        lz_en = 1'b0;
        dp    = '0;
        wait_pos(5);
        do_load(16'h5678);
        wait_pos(20);
        do_load(16'h9999);
        wait_pos(FRAME - 1);
        check_digit("lastwin_d0", 0, 7'b0010000, 4'b1110, 1'b1);
        check_digit("lastwin_d2", 2, 7'b0010000, 4'b1011, 1'b1);

        // Load on the boundary bypasses a stale pending shadow.
        wait_pos(20);
        do_load(16'h4444);
        wait_pos(FRAME - 1);
        check("bypass_fd", 32'(frame_done), 32'h1);
        do_load(16'h0001);
        check_digit("bypass_d0", 0, 7'b1111001, 4'b1110, 1'b1);
        check_digit("bypass_d1", 1, 7'b1000000, 4'b1101, 1'b1);
        wait_pos(FRAME - 1);
        check_digit("stale_gone_d0", 0, 7'b1111001, 4'b1110, 1'b1);

        // Asynchronous reset in the middle of digit 2's drive phase.
        wait_pos(20);
        check("pre_rst_an", 32'(an), 32'hB);
        #2;
        rst_n  = 1'b0;
        in_rst = 1'b1;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_seg", 32'(seg), 32'(B));
        check("async_rst_dp", 32'(dp_o), 32'h1);
        check("async_rst_fd", 32'(frame_done), 32'h0);
        repeat (2) @(posedge clk);
        release_reset();
        check_digit("after_rst_d0", 0, 7'b1000000, 4'b1110, 1'b1);
        check_digit("after_rst_d1", 1, 7'b1000000, 4'b1101, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
